// File: rtl/icb_dec_pkg.sv
// Shared widths, region map and slave IDs for the ICB address decoder.
package icb_dec_pkg;
  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  localparam logic [3:0] REG_IRAM  = 4'h0;
  localparam logic [3:0] REG_SRAM  = 4'h1;
  localparam logic [3:0] REG_SYSIO = 4'h2;

  typedef logic [1:0] sid_t;
  localparam sid_t ID_IRAM  = 2'd0;
  localparam sid_t ID_SRAM  = 2'd1;
  localparam sid_t ID_SYSIO = 2'd2;
  localparam sid_t ID_DEF   = 2'd3;

  function automatic sid_t decode(input logic [MemAddrBus-1:0] addr);
    case (addr[31:28])
      REG_IRAM:  return ID_IRAM;
      REG_SRAM:  return ID_SRAM;
      REG_SYSIO: return ID_SYSIO;
      default:   return ID_DEF;
    endcase
  endfunction
endpackage

// File: rtl/icb_id_fifo.sv
// In-order FIFO of slave IDs for outstanding transactions; no push/pop bypass.
module icb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;

  // Storage needs no reset: entries are only read while cnt says they are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
endmodule

// File: rtl/icb_dec.sv
// ICB 1-to-3 splitter: combinational command decode, responses returned in issue order.
module icb_dec
  import icb_dec_pkg::*;
#(
  parameter int OUTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_icb_cmd_valid,
  output logic                  m_icb_cmd_ready,
  input  logic [MemAddrBus-1:0] m_icb_cmd_addr,
  input  logic                  m_icb_cmd_read,
  input  logic [MemBus-1:0]     m_icb_cmd_wdata,
  input  logic [3:0]            m_icb_cmd_wmask,
  output logic                  m_icb_rsp_valid,
  input  logic                  m_icb_rsp_ready,
  output logic                  m_icb_rsp_err,
  output logic [MemBus-1:0]     m_icb_rsp_rdata,
  output logic [2:0]            s_icb_cmd_valid,
  input  logic [2:0]            s_icb_cmd_ready,
  output logic [MemAddrBus-1:0] s_icb_cmd_addr,
  output logic                  s_icb_cmd_read,
  output logic [MemBus-1:0]     s_icb_cmd_wdata,
  output logic [3:0]            s_icb_cmd_wmask,
  input  logic [2:0]            s_icb_rsp_valid,
  output logic [2:0]            s_icb_rsp_ready,
  input  logic [2:0]            s_icb_rsp_err,
  input  logic [3*MemBus-1:0]   s_icb_rsp_rdata
);
  sid_t sel, head;
  logic full, empty, push, pop;

  // Slot 3 is the default slave: always ready, always answers with an error.
  logic [3:0]             cmd_rdy_all, rsp_vld_all, rsp_err_all, sel_hot, head_hot;
  logic [3:0][MemBus-1:0] rsp_data_all;

  assign sel          = decode(m_icb_cmd_addr);
  assign cmd_rdy_all  = {1'b1, s_icb_cmd_ready};
  assign rsp_vld_all  = {1'b1, s_icb_rsp_valid};
  assign rsp_err_all  = {1'b1, s_icb_rsp_err};
  assign rsp_data_all = {{MemBus{1'b0}}, s_icb_rsp_rdata};
  assign sel_hot      = 4'b0001 << sel;
  assign head_hot     = 4'b0001 << head;

  assign s_icb_cmd_valid = (m_icb_cmd_valid && !full) ? sel_hot[2:0] : 3'b000;
  assign m_icb_cmd_ready = !full && cmd_rdy_all[sel];
  assign s_icb_cmd_addr  = m_icb_cmd_addr;
  assign s_icb_cmd_read  = m_icb_cmd_read;
  assign s_icb_cmd_wdata = m_icb_cmd_wdata;
  assign s_icb_cmd_wmask = m_icb_cmd_wmask;

  always_comb begin
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_err   = 1'b0;
    m_icb_rsp_rdata = '0;
    s_icb_rsp_ready = 3'b000;
    if (!empty) begin
      m_icb_rsp_valid = rsp_vld_all[head];
      m_icb_rsp_err   = rsp_err_all[head];
      m_icb_rsp_rdata = rsp_data_all[head];
      s_icb_rsp_ready = m_icb_rsp_ready ? head_hot[2:0] : 3'b000;
    end
  end

  assign push = m_icb_cmd_valid && m_icb_cmd_ready;
  assign pop  = m_icb_rsp_valid && m_icb_rsp_ready;

  icb_id_fifo #(.DEPTH(OUTS), .W(2)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (sel),
    .head (head),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_icb_dec.sv
// Self-checking bench for icb_dec: directed scenarios then random traffic vs a queue model.
module tb_icb_dec;
  localparam int OUTS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_icb_cmd_valid, m_icb_cmd_ready, m_icb_cmd_read;
  logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_valid, m_icb_rsp_ready, m_icb_rsp_err;
  logic [31:0] m_icb_rsp_rdata;
  logic [2:0]  s_icb_cmd_valid, s_icb_cmd_ready;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic        s_icb_cmd_read;
  logic [3:0]  s_icb_cmd_wmask;
  logic [2:0]  s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [95:0] s_icb_rsp_rdata;

  int tests = 0;
  int fails = 0;
  int q[$];   // slave IDs of outstanding transactions, oldest first

  always #5 clk = ~clk;

  icb_dec #(.OUTS(OUTS)) dut (
    .clk(clk), .rst(rst),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic cyc(input logic v, input logic [31:0] a, input logic rd, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [2:0] scr, input logic mrr,
                     input logic [2:0] srv, input logic [2:0] sre, input logic [95:0] srd);
    int sel, h;
    bit full, exp_crdy, exp_rv, exp_re;
    logic [2:0]  exp_cv, exp_rr;
    logic [31:0] exp_rd;
    m_icb_cmd_valid = v;   m_icb_cmd_addr = a;    m_icb_cmd_read = rd;
    m_icb_cmd_wdata = wd;  m_icb_cmd_wmask = wm;  s_icb_cmd_ready = scr;
    m_icb_rsp_ready = mrr; s_icb_rsp_valid = srv; s_icb_rsp_err = sre;
    s_icb_rsp_rdata = srd;
    #2;
    sel      = (a[31:28] <= 4'h2) ? int'(a[31:28]) : 3;
    full     = (q.size() == OUTS);
    exp_cv   = (v && !full && sel < 3) ? (3'b001 << sel) : 3'b000;
    exp_crdy = !full && (sel == 3 || scr[sel]);
    exp_rv = 1'b0; exp_re = 1'b0; exp_rd = '0; exp_rr = 3'b000;
    if (q.size() > 0) begin
      h = q[0];
      if (h == 3) begin
        exp_rv = 1'b1; exp_re = 1'b1;
      end else begin
        exp_rv = srv[h]; exp_re = sre[h]; exp_rd = srd[32*h +: 32];
        exp_rr = mrr ? (3'b001 << h) : 3'b000;
      end
    end
    chk("s_cmd_valid", 96'(s_icb_cmd_valid), 96'(exp_cv));
    chk("m_cmd_ready", 96'(m_icb_cmd_ready), 96'(exp_crdy));
    chk("s_cmd_fields", {s_icb_cmd_addr, s_icb_cmd_wdata, 27'd0, s_icb_cmd_read, s_icb_cmd_wmask},
        {a, wd, 27'd0, rd, wm});
    chk("m_rsp_valid", 96'(m_icb_rsp_valid), 96'(exp_rv));
    chk("m_rsp_err", 96'(m_icb_rsp_err), 96'(exp_re));
    chk("m_rsp_rdata", 96'(m_icb_rsp_rdata), 96'(exp_rd));
    chk("s_rsp_ready", 96'(s_icb_rsp_ready), 96'(exp_rr));
    @(posedge clk);
    if (q.size() > 0 && exp_rv && mrr) void'(q.pop_front());
    if (v && exp_crdy) q.push_back(sel);
    #1;
  endtask

  task automatic idle(input logic [2:0] srv, input logic [95:0] srd);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 3'b111, 1'b1, srv, 3'b000, srd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    logic [95:0] d;
    logic [3:0]  nib;
    m_icb_cmd_valid = 0; m_icb_cmd_addr = 0; m_icb_cmd_read = 0; m_icb_cmd_wdata = 0;
    m_icb_cmd_wmask = 0; m_icb_rsp_ready = 0; s_icb_cmd_ready = 0; s_icb_rsp_valid = 0;
    s_icb_rsp_err = 0; s_icb_rsp_rdata = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state, then a posted write to slave 1 answered next cycle.
    cyc(1, 32'h1000_0010, 0, 32'hDEAD_BEEF, 4'hF, 3'b111, 1, 3'b000, 3'b000, 96'h0);
    idle(3'b010, 96'h0);
    idle(3'b111, 96'h0);
    chk("empty_after_wr", 96'(q.size()), 96'd0);

    // Out-of-order slave responses are held until the older one returns.
    d = {32'hCAFE_F00D, 32'h0, 32'h1234_5678};
    cyc(1, 32'h0000_0004, 1, 32'h0, 4'h0, 3'b111, 1, 3'b000, 3'b000, d);
    cyc(1, 32'h2000_0000, 1, 32'h0, 4'h0, 3'b111, 1, 3'b000, 3'b000, d);
    repeat (3) idle(3'b100, d);
    idle(3'b101, d);
    idle(3'b100, d);

    // Unmapped read answered by the default slave.
    cyc(1, 32'h8000_0000, 1, 32'h0, 4'h0, 3'b111, 1, 3'b000, 3'b000, 96'h0);
    idle(3'b000, 96'h0);

    // Fill to OUTS, then one pop; no same-cycle refill.
    repeat (5) cyc(1, 32'h1000_0000, 0, 32'h55, 4'hF, 3'b111, 1, 3'b000, 3'b000, 96'h0);
    cyc(1, 32'h1000_0000, 0, 32'h55, 4'hF, 3'b111, 1, 3'b010, 3'b000, 96'h0);
    cyc(1, 32'h1000_0000, 0, 32'h55, 4'hF, 3'b111, 1, 3'b000, 3'b000, 96'h0);
    repeat (4) idle(3'b010, 96'h0);

    // Slave backpressure blocks acceptance.
    cyc(1, 32'h0000_0008, 1, 32'h0, 4'h0, 3'b110, 1, 3'b000, 3'b000, 96'h0);
    idle(3'b111, 96'h0);

    // Reset with three outstanding, then a normal read.
    repeat (3) cyc(1, 32'h1000_0000, 0, 32'h1, 4'h1, 3'b111, 1, 3'b000, 3'b000, 96'h0);
    do_reset();
    idle(3'b111, 96'h0);
    cyc(1, 32'h0000_0000, 1, 32'h0, 4'h0, 3'b111, 1, 3'b000, 3'b000, 96'h0);
    idle(3'b001, {64'h0, 32'hA5A5_0001});

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      nib = ($urandom_range(0, 4) == 4) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      cyc(1'($urandom), {nib, 28'($urandom) & 28'hFFF_FFFC}, 1'($urandom), $urandom,
          4'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
          {$urandom, $urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icb_dec.md
# icb_dec

Address-decoding ICB splitter between the core's system-control stage (single ICB master: load/store traffic, one read at a time, posted writes) and three memory-mapped slaves (instruction RAM, data RAM, system peripherals). It forwards each command to one slave selected by address bits [31:28]. It tracks outstanding transactions in an in-order ID FIFO and routes responses back in issue order. Unmapped addresses are answered by an internal default slave with an error response.

## Interface
- `OUTS`, 4: max outstanding transactions (power of two, 2..16).
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `m_icb_cmd_valid` input 1: master command valid.
- `m_icb_cmd_ready` output 1: command accepted this cycle when high with valid.
- `m_icb_cmd_addr` input 32: word-aligned address.
- `m_icb_cmd_read` input 1: 1 = read, 0 = write.
- `m_icb_cmd_wdata` input 32: write data.
- `m_icb_cmd_wmask` input 4: byte strobes.
- `m_icb_rsp_valid` output 1: response valid.
- `m_icb_rsp_ready` input 1: master accepts response.
- `m_icb_rsp_err` output 1: response error.
- `m_icb_rsp_rdata` output 32: read data.
- `s_icb_cmd_valid` output 3: per-slave command valid; bit i is slave i.
- `s_icb_cmd_ready` input 3: per-slave command ready.
- `s_icb_cmd_addr` output 32: shared address to all slaves.
- `s_icb_cmd_read` output 1: shared read flag.
- `s_icb_cmd_wdata` output 32: shared write data.
- `s_icb_cmd_wmask` output 4: shared write mask.
- `s_icb_rsp_valid` input 3: per-slave response valid.
- `s_icb_rsp_ready` output 3: per-slave response ready.
- `s_icb_rsp_err` input 3: per-slave response error.
- `s_icb_rsp_rdata` input 96: per-slave read data; slave i occupies bits [32i+31:32i].

## Operation
- Decode of addr[31:28]:
  - 0x0 → slave 0.
  - 0x1 → slave 1.
  - 0x2 → slave 2.
  - any other value → default slave (ID 3).
- Command path is combinational, with no register stage.
  - Accept condition: `s_icb_cmd_valid[sel] = m_icb_cmd_valid & ~full`.
  - `m_icb_cmd_ready = ~full & (sel==3 ? 1 : s_icb_cmd_ready[sel])`.
  - Shared cmd fields pass through unchanged.
- On each accepted command (valid & ready), the 2-bit ID `sel` is pushed into the ID FIFO.
- Response path is driven by the FIFO head ID `h`, gated by `~empty`.
  - For h<3: `m_icb_rsp_valid = s_icb_rsp_valid[h]`, with err and rdata taken from slave h.
  - `s_icb_rsp_ready[h] = m_icb_rsp_ready`. All other `s_icb_rsp_ready` bits are 0.
  - For h==3 (default slave): `m_icb_rsp_valid = 1`, `err = 1`, `rdata = 0`.
- A response handshake (`m_icb_rsp_valid & m_icb_rsp_ready`) pops the FIFO.
- Responses from non-head slaves are stalled (ready held 0), never dropped.
- When empty:
  - `m_icb_rsp_valid = 0`, `err = 0`, `rdata = 0`.
  - All `s_icb_rsp_ready` bits are 0.
- Full is `count == OUTS`. There is no same-cycle bypass: a pop while full does not enable a push in that cycle.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Push into an empty FIFO: the response may appear no earlier than the next cycle. The default slave answers exactly 1 cycle after acceptance if `m_icb_rsp_ready=1`.
- Pointers are `$clog2(OUTS)` bits and wrap modulo OUTS. `count` is `$clog2(OUTS)+1` bits.
- Reset: pointers and count cleared. In-flight transactions are discarded; slaves are reset by the same `rst`.

## Timing
- Reset values after `rst`:
  - `m_icb_rsp_valid = 0`, `m_icb_rsp_err = 0`, `m_icb_rsp_rdata = 0`.
  - `s_icb_rsp_ready = 0`.
  - `s_icb_cmd_valid` follows `m_icb_cmd_valid` (FIFO empty, not full).
- Command latency: 0 cycles (combinational pass-through).
- Minimum response latency: 1 cycle after command acceptance.
- Throughput: 1 command per cycle and 1 response per cycle, in parallel.
- Ordering: responses are returned strictly in command-acceptance order.
- No combinational path from `m_icb_rsp_ready` to `m_icb_cmd_ready`.

## Structure
- Shared package/defines:
  - `MemAddrBus` and `MemBus` widths (32).
  - Region nibbles `REG_IRAM=4'h0`, `REG_SRAM=4'h1`, `REG_SYSIO=4'h2`.
  - Slave IDs 0..3, with `ID_DEF=2'd3`.
- Sub-module `icb_id_fifo`:
  - Parameterised depth OUTS, width 2.
  - Ports: push, pop, din, head, full, empty.
- Top level holds the decoder and the response mux.

## Test plan
- Write to 0x1000_0010, data 0xDEADBEEF, mask 4'hF: `s_icb_cmd_valid=3'b010`, fields unchanged. Slave 1 responds a cycle later: `m_icb_rsp_valid=1`, `err=0`, FIFO empty after.
- Read 0x0000_0004, then read 0x2000_0000. Slave 2 responds first, slave 0 responds 3 cycles later. Required: `s_icb_rsp_ready[2]` stays 0 until slave 0's rdata (0x12345678) is delivered, then slave 2's rdata is delivered.
- Read 0x8000_0000: no `s_icb_cmd_valid` bit set. Next cycle `m_icb_rsp_valid=1`, `err=1`, `rdata=0`.
- OUTS=4, five back-to-back writes to slave 1, slave 1 withholding responses: `m_icb_cmd_ready` drops on the 5th write. It rises again only in the cycle after the first response pop.
- `s_icb_cmd_ready[0]=0` with a command to slave 0: `m_icb_cmd_ready=0`, no FIFO push, count stays 0.
- Assert `rst` with 3 transactions outstanding: next cycle `m_icb_rsp_valid=0` and `count=0`. A subsequent read to slave 0 completes normally.
